alu_share_arbiter: RTL and testbench

- Shares the single integer ALU between NREQ requesters (e.g. execute-stage operand path and branch/address-compute path) with round-robin arbitration.
- Drives the ALU operand/control inputs combinationally from the granted requester.
- Captures result and flags in a one-entry registered output stage with valid/ready handshake.
- The ALU itself is instantiated by the parent; this block only sequences access to it.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_share_arbiter_if.sv | 45 ++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/alu_share_arbiter.sv | 86 ++++++++
 tb/tb_alu_share_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op encodings, flag bit positions and request bundle type.
// Imported by the ALU sharing arbiter and its users.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b110;

    localparam logic [1:0] FLG_Z = 2'd3;
    localparam logic [1:0] FLG_N = 2'd2;
    localparam logic [1:0] FLG_C = 2'd1;
    localparam logic [1:0] FLG_V = 2'd0;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      cntrl;
    } alu_req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU and response signals of the shared ALU arbiter.
// master = requesters/ALU/consumer side, slave = arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_a;
    logic [NREQ-1:0][WIDTH-1:0] req_b;
    logic [NREQ-1:0][2:0]       req_cntrl;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_cntrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_negative;
    logic             alu_carry;
    logic             alu_over_flow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_cntrl,
        output alu_result, alu_zero, alu_negative,
        output alu_carry, alu_over_flow, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_cntrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cntrl,
        input  alu_result, alu_zero, alu_negative,
        input  alu_carry, alu_over_flow, rsp_ready,
        output req_ready, alu_a, alu_b, alu_cntrl,
        output rsp_valid, rsp_id, rsp_result, rsp_flags
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or above ptr wins, wrapping.
// The pointer moves past the winner only when adv is asserted.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] idx;

    // with no request, grant_idx rests on ptr so the ALU mux stays defined
    always_comb begin
        grant     = '0;
        grant_idx = ptr_q;
        any       = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU between NREQ requesters with round-robin grant
// and a one-entry registered result stage.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic clk,
    input logic rst,
    alu_share_arbiter_if.slave bus
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any;
    logic            can_accept;
    logic            xfer;

    rsp_state_e       state_q;
    rsp_state_e       state_d;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .adv       (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign can_accept = !rst && (state_q == EMPTY || bus.rsp_ready);
    assign xfer       = any && can_accept;

    assign bus.req_ready = grant & {NREQ{can_accept}};
    assign bus.alu_a     = bus.req_a[grant_idx];
    assign bus.alu_b     = bus.req_b[grant_idx];
    assign bus.alu_cntrl = bus.req_cntrl[grant_idx];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (bus.rsp_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // a new transfer overwrites the slot even while it drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (xfer) begin
            id_q           <= grant_idx;
            result_q       <= bus.alu_result;
            flags_q[FLG_Z] <= bus.alu_zero;
            flags_q[FLG_N] <= bus.alu_negative;
            flags_q[FLG_C] <= bus.alu_carry;
            flags_q[FLG_V] <= bus.alu_over_flow;
        end
    end

    assign bus.rsp_valid  = (state_q == FULL);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cnt0;
    int   cnt1;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference ALU: {result, zero, negative, carry, over_flow}
    function automatic logic [35:0] alu_eval(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [2:0]  op);
        logic [32:0] s;
        logic [31:0] r;
        logic c;
        logic v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            default: r = '0;
        endcase
        return {r, (r == 32'd0), r[31], c, v};
    endfunction

    always_comb begin
        {bus.alu_result, bus.alu_zero, bus.alu_negative,
         bus.alu_carry, bus.alu_over_flow} =
            alu_eval(bus.alu_a, bus.alu_b, bus.alu_cntrl);
    end

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j = (p + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // model: one response slot plus a rotating priority pointer
    logic             m_full = 1'b0;
    int               m_ptr  = 0;
    int               m_id   = 0;
    logic [31:0]      m_res  = '0;
    logic [3:0]       m_flg  = '0;
    logic [NREQ-1:0]  acc    = '0;

    always @(posedge clk or posedge rst) begin : model
        int g;
        logic [35:0] r;
        if (rst) begin
            m_full <= 1'b0;
            m_ptr  <= 0;
            m_id   <= 0;
            m_res  <= '0;
            m_flg  <= '0;
            acc    <= '0;
        end else begin
            g = pick(bus.req_valid, m_ptr);
            acc <= '0;
            if (g >= 0 && (!m_full || bus.rsp_ready)) begin
                r = alu_eval(bus.req_a[g], bus.req_b[g], bus.req_cntrl[g]);
                acc[g] <= 1'b1;
                m_res  <= r[35:4];
                m_flg  <= r[3:0];
                m_id   <= g;
                m_full <= 1'b1;
                m_ptr  <= (g + 1) % NREQ;
            end else if (m_full && bus.rsp_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        int sel;
        logic [NREQ-1:0] er;
        if (!rst) begin
            g  = pick(bus.req_valid, m_ptr);
            er = '0;
            if (g >= 0 && (!m_full || bus.rsp_ready)) er[g] = 1'b1;
            sel = (g >= 0) ? g : m_ptr;
            chk("m_req_ready", bus.req_ready, er);
            chk("m_alu_a", bus.alu_a, bus.req_a[sel]);
            chk("m_alu_b", bus.alu_b, bus.req_b[sel]);
            chk("m_alu_cntrl", bus.alu_cntrl, bus.req_cntrl[sel]);
            chk("m_rsp_valid", bus.rsp_valid, m_full);
            if (m_full) begin
                chk("m_rsp_id", bus.rsp_id, m_id);
                chk("m_rsp_result", bus.rsp_result, m_res);
                chk("m_rsp_flags", bus.rsp_flags, m_flg);
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold
        assert property (@(posedge clk) disable iff (rst)
            (bus.req_valid[gi] && !bus.req_ready[gi]) |=> bus.req_valid[gi])
            else $error("requester %0d dropped valid before ready", gi);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input alu_req_t r);
        bus.req_a[i]     = r.a;
        bus.req_b[i]     = r.b;
        bus.req_cntrl[i] = r.cntrl;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(3))
            0:       return 32'h0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [2:0] rnd_op();
        case ($urandom_range(3))
            0:       return ALU_ADD;
            1:       return ALU_SUB;
            2:       return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cntrl = '0;
        bus.rsp_ready = 1'b0;
        step();
        step();
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_flags", bus.rsp_flags, 0);
        bus.req_valid = '0;
        rst = 1'b0;
        step();

        put(0, '{a: 32'd5, b: 32'd3, cntrl: ALU_ADD});
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        #1;
        chk("t1_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid = '0;
        chk("t1_valid", bus.rsp_valid, 1);
        chk("t1_id", bus.rsp_id, 0);
        chk("t1_result", bus.rsp_result, 32'd8);
        chk("t1_flags", bus.rsp_flags, 4'b0000);

        put(1, '{a: 32'd3, b: 32'd5, cntrl: ALU_SUB});
        bus.req_valid = 2'b10;
        #1;
        chk("t2_ready", bus.req_ready, 2'b10);
        step();
        bus.req_valid = '0;
        chk("t2_id", bus.rsp_id, 1);
        chk("t2_result", bus.rsp_result, 32'hFFFF_FFFE);
        chk("t2_flags", bus.rsp_flags, 4'b0100);

        put(0, '{a: 32'd10, b: 32'd20, cntrl: ALU_ADD});
        put(1, '{a: 32'hF0, b: 32'h0F, cntrl: ALU_OR});
        bus.req_valid = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            cnt0 += int'(bus.req_ready[0]);
            cnt1 += int'(bus.req_ready[1]);
            step();
            chk("t3_id", bus.rsp_id, k % 2);
        end
        chk("t3_cnt0", cnt0, 2);
        chk("t3_cnt1", cnt1, 2);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = '0;
        chk("t3_tail_id", bus.rsp_id, 0);
        step();
        chk("t3_drain", bus.rsp_valid, 0);

        bus.req_valid = 2'b11;
        step();
        chk("t4_first_id", bus.rsp_id, 1);
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_stall_ready", bus.req_ready, 0);
            step();
            chk("t4_stall_valid", bus.rsp_valid, 1);
            chk("t4_stall_id", bus.rsp_id, 1);
            chk("t4_stall_result", bus.rsp_result, 32'hFF);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("t4_b2b_ready", bus.req_ready, 2'b01);
        step();
        chk("t4_b2b_id", bus.rsp_id, 0);
        chk("t4_b2b_result", bus.rsp_result, 32'd30);
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = '0;
        chk("t4_tail_id", bus.rsp_id, 1);
        step();

        put(0, '{a: 32'h7FFF_FFFF, b: 32'd1, cntrl: ALU_ADD});
        bus.req_valid = 2'b01;
        step();
        chk("t5_ovf_result", bus.rsp_result, 32'h8000_0000);
        chk("t5_ovf_flags", bus.rsp_flags, 4'b0101);
        put(0, '{a: 32'hA5A5_0F0F, b: 32'hA5A5_0F0F, cntrl: ALU_SUB});
        step();
        bus.req_valid = '0;
        chk("t5_zero_result", bus.rsp_result, 32'd0);
        chk("t5_zero_flag", bus.rsp_flags[FLG_Z], 1);
        step();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || acc[i]) begin
                    if ($urandom_range(99) < 60) begin
                        bus.req_valid[i] = 1'b1;
                        put(i, '{a: rnd_opnd(), b: rnd_opnd(),
                                 cntrl: rnd_op()});
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
            bus.rsp_ready = ($urandom_range(99) < 70);
            step();
        end

        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", bus.rsp_valid, 0);
        chk("t6_rst_ready", bus.req_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("t6_post_ready", bus.req_ready, 2'b01);
        bus.rsp_ready = 1'b1;
        step();
        chk("t6_post_valid", bus.rsp_valid, 1);
        chk("t6_post_id", bus.rsp_id, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
